// File: rtl/data_memory_responder_if.sv
// Core-side data-memory bus between the LEGv8 MEM stage and the responder.
//   memRead   : read enable
//   memWrite  : write enable
//   address   : byte address
//   writeData : store data
//   readData  : load data, combinational from the responder
// master = core side, slave = memory responder side.
interface data_memory_responder_if #(
   parameter int N = 64
);
   logic         memRead;
   logic         memWrite;
   logic [N-1:0] address;
   logic [N-1:0] writeData;
   logic [N-1:0] readData;

   modport master (
      output memRead,
      output memWrite,
      output address,
      output writeData,
      input  readData
   );

   modport slave (
      input  memRead,
      input  memWrite,
      input  address,
      input  writeData,
      output readData
   );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder for the pipelined LEGv8 core.
// Holds DEPTH N-bit words, byte addressed. Reads are combinational and writes
// are synchronous. Misaligned or out-of-range accesses are rejected and
// flagged. A dump engine streams the whole image out one word per cycle.
//
// Ports:
//   clk            : rising-edge clock
//   reset          : asynchronous active-high reset
//   bus            : core MEM-stage bus (slave modport)
//   dump_start     : one-cycle request to stream the memory out
//   dump_valid     : dump_index/dump_data valid this cycle
//   dump_index     : word index of dump_data
//   dump_data      : dumped word
//   dump_done      : one-cycle pulse after the last dumped word
//   err_misaligned : sticky, an access had address[2:0] != 0
//   err_range      : sticky, an access had address >= DEPTH*8
//   err_addr       : address of the first erroneous access
//   rd_count       : accepted reads, wraps
//   wr_count       : accepted writes, wraps
//
// Dump FSM:
//   state  | meaning
//   IDLE   | waiting for dump_start
//   DUMP   | emitting word ptr each cycle, ptr = 0 .. DEPTH-1
//   DONE   | one cycle with dump_done high, then back to IDLE
module data_memory_responder #(
   parameter int N     = 64,
   parameter int DEPTH = 64,
   parameter int CW    = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        reset,
   data_memory_responder_if.slave      bus,
   input  logic                        dump_start,
   output logic                        dump_valid,
   output logic [AW-1:0]               dump_index,
   output logic [N-1:0]                dump_data,
   output logic                        dump_done,
   output logic                        err_misaligned,
   output logic                        err_range,
   output logic [N-1:0]                err_addr,
   output logic [CW-1:0]               rd_count,
   output logic [CW-1:0]               wr_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DUMP = 2'd1,
      S_DONE = 2'd2
   } dump_state_t;

   logic [N-1:0]  mem [DEPTH];

   logic          misaligned;
   logic          out_of_range;
   logic          addr_ok;
   logic          access;
   logic [AW-1:0] word_idx;

   dump_state_t   state;
   dump_state_t   state_nxt;
   logic [AW-1:0] ptr;
   logic [AW-1:0] ptr_nxt;
   logic          valid_nxt;
   logic          done_nxt;
   logic          capture;

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   always_comb begin
      misaligned   = |bus.address[2:0];
      // Any bit at or above DEPTH*8 means the address is past the array.
      out_of_range = |bus.address[N-1:AW+3];
      addr_ok      = !misaligned && !out_of_range;
      word_idx     = bus.address[AW+2:3];
      access       = bus.memRead || bus.memWrite;
   end

   // Combinational read; a same-cycle write lands at the edge, so a combined
   // read/write returns the old contents.
   always_comb begin
      bus.readData = '0;
      if (bus.memRead && addr_ok) begin
         bus.readData = mem[word_idx];
      end
   end

   // ---------------------------------------------------------------------
   // Storage; reset loads word i with i so a fresh image is recognisable.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= N'(i);
         end
      end else if (bus.memWrite && addr_ok) begin
         mem[word_idx] <= bus.writeData;
      end
   end

   // ---------------------------------------------------------------------
   // Access counters and error capture
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_count       <= '0;
         wr_count       <= '0;
         err_misaligned <= 1'b0;
         err_range      <= 1'b0;
         err_addr       <= '0;
      end else if (access) begin
         if (addr_ok) begin
            if (bus.memRead) begin
               rd_count <= rd_count + CW'(1);
            end
            if (bus.memWrite) begin
               wr_count <= wr_count + CW'(1);
            end
         end else begin
            // err_addr keeps only the first offender.
            if (!err_misaligned && !err_range) begin
               err_addr <= bus.address;
            end
            if (misaligned) begin
               err_misaligned <= 1'b1;
            end
            if (out_of_range) begin
               err_range <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Dump FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (dump_start) begin
               state_nxt = S_DUMP;
               ptr_nxt   = '0;
            end
         end
         S_DUMP: begin
            valid_nxt = 1'b1;
            capture   = 1'b1;
            ptr_nxt   = ptr + AW'(1);
            if (ptr == AW'(DEPTH - 1)) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ptr        <= '0;
         dump_valid <= 1'b0;
         dump_done  <= 1'b0;
         dump_index <= '0;
         dump_data  <= '0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         dump_valid <= valid_nxt;
         dump_done  <= done_nxt;
         // mem[ptr] is sampled before any same-edge write takes effect.
         if (capture) begin
            dump_index <= ptr;
            dump_data  <= mem[ptr];
         end
      end
   end

endmodule
